weight_stream_sram: RTL and testbench
=====================================

// Module: weight_stream_sram
// PURPOSE
// - Parametrised per-neuron weight store for the MLP datapath: random-access write/read port plus a
//   burst stream port that feeds consecutive weights to the neuron MAC under valid/ready.
// - Registered read (1-cycle latency), write-first collision bypass, out-of-range protection.
// - Loaded by the layer controller; streamed by the neuron sequencer once per inference.
// PARAMETERS
// - WEIGHT_WIDTH  32                  bits per weight word
// - DEPTH         16                  number of weight words (>= 2)
// - ADDR_WIDTH    $clog2(DEPTH)+1     address width; MSB headroom allows out-of-range detection
// PORTS
// - clk            in   1             single clock, all state on posedge
// - rst            in   1             asynchronous, active-high reset
// - wr_en          in   1             write strobe
// - wr_addr        in   ADDR_WIDTH    write address
// - wr_data        in   WEIGHT_WIDTH  write data
// - rd_en          in   1             random read request
// - rd_addr        in   ADDR_WIDTH    random read address
// - rd_data        out  WEIGHT_WIDTH  random read data; 0 whenever rd_valid=0
// - rd_valid       out  1             rd_data valid; pulses 1 cycle after rd_en
// - stream_start   in   1             start burst; honoured only in IDLE
// - stream_base    in   ADDR_WIDTH    first word of burst (must be < DEPTH)
// - stream_len     in   ADDR_WIDTH    burst length; 0 means DEPTH
// - stream_abort   in   1             kill burst immediately
// - stream_data    out  WEIGHT_WIDTH  streamed weight
// - stream_valid   out  1             stream_data valid
// - stream_ready   in   1             consumer accepts when valid & ready
// - stream_last    out  1             qualifies final word of burst
// - busy           out  1             high while state != IDLE
// BEHAVIOUR
// - Reset: rd_data=0, rd_valid=0, stream_data=0, stream_valid=0, stream_last=0, busy=0, FSM=IDLE.
//   Memory array is not reset; contents are undefined until written.
// - Write: on posedge with wr_en & wr_addr<DEPTH, mem[wr_addr]<=wr_data. wr_addr>=DEPTH: dropped.
// - Random read: rd_en at edge N -> rd_valid=1, rd_data=mem[rd_addr] during cycle N+1.
//   rd_addr>=DEPTH -> rd_valid=1, rd_data=0. Without rd_en, rd_data returns to 0.
// - Collision: same-edge write and read (either port) to same address returns wr_data (write-first).
// - FSM IDLE -> RUN on stream_start: latch ptr=stream_base, remaining=(len==0?DEPTH:len), busy=1.
//   stream_base>=DEPTH: start ignored, stays IDLE.
// - RUN load condition: remaining>0 & (!stream_valid | stream_ready) & !rd_en.
//   On load: stream_data<=mem[ptr] (bypass applies), stream_valid<=1, stream_last<=(remaining==1),
//   ptr<=(ptr==DEPTH-1)?0:ptr+1 (wrap), remaining--. Accept without load: stream_valid<=0.
// - First word valid the cycle after start at the earliest; full throughput 1 word/cycle with ready=1.
// - Port priority: rd_en wins the single read port; stream stalls that cycle, holds stream_data stable.
// - stream_valid & !stream_ready: stream_data/stream_last held unchanged (AXI-style stability).
// - RUN -> IDLE on accept of stream_last word; busy drops the following cycle.
// - stream_abort (any state): next cycle stream_valid=0, stream_last=0, FSM=IDLE; abort beats start.
// - stream_start while RUN: ignored. Writes during RUN permitted; unread words reflect new data.
// STRUCTURE
// - Package mlp_pkg: typedef enum logic {IDLE, RUN} stream_state_t; weight_t parametrised via localparam.
// - Sub-module weight_mem_core: storage array + registered read + write-first bypass; this top holds
//   FSM, pointer/counter, port arbitration, output hold register.
// TESTING
// - Reset mid-RUN (rst high 1 cycle at word 3 of 8) -> all outputs 0, busy=0, IDLE next cycle.
// - Write mem[i]=i*3+1 for i=0..15; rd_en addr 5 -> next cycle rd_valid=1, rd_data=16; addr 20 -> rd_data=0.
// - Same-edge wr addr 7 data 0xDEAD + rd addr 7 -> rd_data=0xDEAD next cycle.
// - Stream base=14 len=4, ready=1 -> words mem[14],mem[15],mem[0],mem[1] back-to-back, last on 4th, busy 0 after.
// - Stream len=0 with ready toggling 1,0 -> 16 words in order, data held stable on ready=0 cycles.
// - rd_en asserted during stream word 2 -> stream stalls one cycle, no word lost/duplicated.
// - stream_abort after 2 accepted words -> valid=0 next cycle, IDLE; new start base=0 len=1 -> single word, last=1.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP weight store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mlp_pkg;

  localparam int DEF_WEIGHT_WIDTH = 32;
  localparam int DEF_DEPTH        = 16;
  localparam int DEF_ADDR_WIDTH   = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic {
    IDLE,
    RUN
  } stream_state_t;

endpackage

// File: rtl/weight_stream_sram_if.sv
// Bus bundle for the weight store: random write/read port plus burst stream port.
// Latency: n/a (wiring only).
// Backpressure: stream_ready from the consumer side, valid/ready handshake.
interface weight_stream_sram_if #(
  parameter int WEIGHT_WIDTH = mlp_pkg::DEF_WEIGHT_WIDTH,
  parameter int ADDR_WIDTH   = mlp_pkg::DEF_ADDR_WIDTH
);

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [WEIGHT_WIDTH-1:0] wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [WEIGHT_WIDTH-1:0] rd_data;
  logic                    rd_valid;
  logic                    stream_start;
  logic [ADDR_WIDTH-1:0]   stream_base;
  logic [ADDR_WIDTH-1:0]   stream_len;
  logic                    stream_abort;
  logic [WEIGHT_WIDTH-1:0] stream_data;
  logic                    stream_valid;
  logic                    stream_ready;
  logic                    stream_last;
  logic                    busy;

  // controller / consumer side
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  rd_data, rd_valid,
    output stream_start, stream_base, stream_len, stream_abort, stream_ready,
    input  stream_data, stream_valid, stream_last, busy
  );

  // weight store side
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output rd_data, rd_valid,
    input  stream_start, stream_base, stream_len, stream_abort, stream_ready,
    output stream_data, stream_valid, stream_last, busy
  );

endinterface

// File: rtl/weight_mem_core.sv
// Weight storage array with one write port and one registered read port.
// Latency: 1 cycle from rd_req to rd_q; same-edge write to the read address is forwarded.
// Backpressure: none; rd_q holds its value while rd_req is low.
module weight_mem_core
  import mlp_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [WEIGHT_WIDTH-1:0] rd_q
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [WEIGHT_WIDTH-1:0] mem [DEPTH];
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    fwd;

  // Addresses at or beyond DEPTH never touch the array.
  assign wr_ok = wr_en && (wr_addr < DEPTH_A);
  assign rd_ok = rd_addr < DEPTH_A;
  assign fwd   = wr_ok && (wr_addr == rd_addr);

  // Storage array; deliberately not reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Registered read: out-of-range reads return zero, same-edge write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_req) begin
      if (!rd_ok) begin
        rd_q <= '0;
      end else if (fwd) begin
        rd_q <= wr_data;
      end else begin
        rd_q <= mem[rd_addr[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/weight_stream_sram.sv
// Per-neuron weight store: random read/write port plus burst stream to the MAC.
// Latency: random read 1 cycle; first stream word 2 cycles after start, then 1 word/cycle.
// Backpressure: stream holds data/last while valid & !ready; random reads steal the read port.
module weight_stream_sram
  import mlp_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_stream_sram_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  stream_state_t           state;
  stream_state_t           state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   ptr_nxt;
  logic [ADDR_WIDTH-1:0]   remaining;
  logic [ADDR_WIDTH-1:0]   remaining_nxt;
  logic                    stream_valid_q;
  logic                    stream_valid_nxt;
  logic                    stream_last_q;
  logic                    stream_last_nxt;
  logic                    load;
  logic                    last_load;
  logic                    rd_valid_q;
  logic                    core_rd;
  logic [ADDR_WIDTH-1:0]   core_addr;
  logic [WEIGHT_WIDTH-1:0] core_q;
  logic [WEIGHT_WIDTH-1:0] stream_hold;

  // Single read port: a random read always wins, the stream only reads on a load.
  assign core_rd   = bus.rd_en | load;
  assign core_addr = bus.rd_en ? bus.rd_addr : ptr;

  weight_mem_core #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_req  (core_rd),
    .rd_addr (core_addr),
    .rd_q    (core_q)
  );

  // Next-state: burst start, word loads, handshake retire and abort.
  always_comb begin
    state_nxt        = state;
    ptr_nxt          = ptr;
    remaining_nxt    = remaining;
    stream_valid_nxt = stream_valid_q;
    stream_last_nxt  = stream_last_q;
    load             = 1'b0;
    if (bus.stream_abort) begin
      state_nxt        = IDLE;
      stream_valid_nxt = 1'b0;
      stream_last_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.stream_start && (bus.stream_base < DEPTH_A)) begin
            state_nxt     = RUN;
            ptr_nxt       = bus.stream_base;
            remaining_nxt = (bus.stream_len == '0) ? DEPTH_A : bus.stream_len;
          end
        end
        RUN: begin
          if ((remaining != '0) && (!stream_valid_q || bus.stream_ready) && !bus.rd_en) begin
            load             = 1'b1;
            stream_valid_nxt = 1'b1;
            stream_last_nxt  = (remaining == ONE_A);
            ptr_nxt          = (ptr == LAST_A) ? '0 : ptr + ONE_A;
            remaining_nxt    = remaining - ONE_A;
          end else if (stream_valid_q && bus.stream_ready) begin
            stream_valid_nxt = 1'b0;
            stream_last_nxt  = 1'b0;
            if (stream_last_q) begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst pointer, word counter and stream handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      remaining      <= '0;
      stream_valid_q <= 1'b0;
      stream_last_q  <= 1'b0;
      last_load      <= 1'b0;
    end else begin
      ptr            <= ptr_nxt;
      remaining      <= remaining_nxt;
      stream_valid_q <= stream_valid_nxt;
      stream_last_q  <= stream_last_nxt;
      last_load      <= load;
    end
  end

  // Keep the presented stream word stable once the shared read register moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_hold <= '0;
    end else if (last_load) begin
      stream_hold <= core_q;
    end
  end

  // Random read valid follows rd_en by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_valid_q ? core_q : '0;
  assign bus.stream_data  = last_load ? core_q : stream_hold;
  assign bus.stream_valid = stream_valid_q;
  assign bus.stream_last  = stream_last_q;
  assign bus.busy         = (state == RUN);

endmodule

// File: tb/tb_weight_stream_sram.sv
// Randomized and directed bench for weight_stream_sram against a behavioural model.
// The model keeps a word array and, per burst, a queue of expected words.
// Outputs are sampled 1 time unit after each rising edge.
module tb_weight_stream_sram;

  localparam int AW = mlp_pkg::DEF_ADDR_WIDTH;
  localparam int D  = mlp_pkg::DEF_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  weight_stream_sram_if bus ();

  weight_stream_sram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  bit run    = 1'b0;
  logic [31:0] ref_mem [D];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    bus.stream_start = 1'b0;
    bus.stream_base  = '0;
    bus.stream_len   = '0;
    bus.stream_abort = 1'b0;
    bus.stream_ready = 1'b0;
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic cycle();
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [31:0] w;
    logic        hold;
    logic [31:0] held_d;
    logic        held_l;
    logic        abort_now;
    bit          run_pre;
    int          n;
    run_pre   = run;
    abort_now = bus.stream_abort;
    exp_rv    = bus.rd_en;
    exp_rd    = '0;
    if (bus.rd_en && (int'(bus.rd_addr) < D)) begin
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) exp_rd = bus.wr_data;
      else exp_rd = ref_mem[bus.rd_addr[3:0]];
    end
    if (bus.stream_valid && bus.stream_ready && !abort_now) begin
      if (exp_q.size() == 0) begin
        chk("stream_spurious", 1, 0);
      end else begin
        w = exp_q.pop_front();
        n_acc++;
        chk("stream_data", bus.stream_data, w);
        chk("stream_last", bus.stream_last, (exp_q.size() == 0));
        if (exp_q.size() == 0) run = 1'b0;
      end
    end
    hold   = bus.stream_valid && !bus.stream_ready && !abort_now;
    held_d = bus.stream_data;
    held_l = bus.stream_last;
    if (abort_now) begin
      exp_q.delete();
      run = 1'b0;
    end
    if (bus.wr_en && (int'(bus.wr_addr) < D)) ref_mem[bus.wr_addr[3:0]] = bus.wr_data;
    if (bus.stream_start && !run_pre && !abort_now && (int'(bus.stream_base) < D)) begin
      n = (bus.stream_len == '0) ? D : int'(bus.stream_len);
      for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[(int'(bus.stream_base) + k) % D]);
      run = 1'b1;
    end
    tick();
    chk("rd_valid", bus.rd_valid, exp_rv);
    chk("rd_data", bus.rd_data, exp_rd);
    if (hold) begin
      chk("hold_valid", bus.stream_valid, 1);
      chk("hold_data", bus.stream_data, held_d);
      chk("hold_last", bus.stream_last, held_l);
    end
    if (abort_now) begin
      chk("abort_valid", bus.stream_valid, 0);
      chk("abort_last", bus.stream_last, 0);
    end
    chk("busy", bus.busy, run);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_stream_data", bus.stream_data, 0);
    chk("rst_stream_valid", bus.stream_valid, 0);
    chk("rst_stream_last", bus.stream_last, 0);
    chk("rst_busy", bus.busy, 0);
    exp_q.delete();
    run = 1'b0;
    rst = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < D; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(i);
      bus.wr_data = 32'(i * 3 + 1);
      cycle();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic start_burst(input int base, input int len);
    bus.stream_start = 1'b1;
    bus.stream_base  = AW'(base);
    bus.stream_len   = AW'(len);
    cycle();
    bus.stream_start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && run; k++) cycle();
    chk(tag, run, 0);
  endtask

  task automatic wait_acc(input string tag, input int target);
    for (int k = 0; k < 100 && (n_acc < target); k++) cycle();
    chk(tag, (n_acc >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int vcyc;
    bit found;
    idle_inputs();
    tick();
    do_reset();
    load_mem();

    // random reads, out-of-range, return to zero, collision
    bus.rd_en = 1'b1; bus.rd_addr = AW'(5);
    cycle();
    chk("rd_addr5", bus.rd_data, 16);
    bus.rd_addr = AW'(20);
    cycle();
    chk("rd_oor_data", bus.rd_data, 0);
    chk("rd_oor_valid", bus.rd_valid, 1);
    bus.rd_en = 1'b0;
    cycle();
    chk("rd_idle_data", bus.rd_data, 0);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(7); bus.wr_data = 32'hDEAD;
    bus.rd_en = 1'b1; bus.rd_addr = AW'(7);
    cycle();
    chk("rd_collide", bus.rd_data, 32'hDEAD);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = AW'(20); bus.wr_data = 32'h5555;
    cycle();
    bus.wr_en = 1'b0;

    // wrapping burst at full throughput
    bus.stream_ready = 1'b1;
    a0 = n_acc;
    start_burst(14, 4);
    vcyc = 0;
    for (int k = 0; k < 20 && run; k++) begin
      if (bus.stream_valid) vcyc++;
      cycle();
    end
    chk("b2b_valid_cycles", vcyc, 4);
    chk("b2b_words", n_acc - a0, 4);
    chk("b2b_busy_after", bus.busy, 0);

    // len 0 means full depth, ready toggling
    a0 = n_acc;
    bus.stream_ready = 1'b0;
    start_burst(0, 0);
    for (int k = 0; k < 200 && run; k++) begin
      bus.stream_ready = k[0];
      cycle();
    end
    chk("full_done", run, 0);
    chk("full_words", n_acc - a0, 16);

    // random read steals the port during word 2
    bus.stream_ready = 1'b1;
    a0 = n_acc;
    start_burst(2, 6);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if ((n_acc - a0 == 1) && bus.stream_valid) found = 1'b1;
      else cycle();
    end
    chk("stall_reached", found, 1);
    bus.rd_en = 1'b1; bus.rd_addr = AW'(9);
    cycle();
    bus.rd_en = 1'b0;
    chk("stall_valid", bus.stream_valid, 0);
    drain("stall_drain");
    chk("stall_words", n_acc - a0, 6);

    // abort after two words, then single-word burst
    a0 = n_acc;
    start_burst(3, 8);
    wait_acc("abort_reach", a0 + 2);
    bus.stream_ready = 1'b0;
    bus.stream_abort = 1'b1;
    cycle();
    bus.stream_abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    bus.stream_ready = 1'b1;
    a0 = n_acc;
    start_burst(0, 1);
    drain("single_drain");
    chk("single_words", n_acc - a0, 1);

    // out-of-range base is ignored
    start_burst(18, 2);
    chk("bad_base_busy", bus.busy, 0);

    // reset in the middle of an 8-word burst
    a0 = n_acc;
    start_burst(0, 8);
    wait_acc("rst_reach", a0 + 3);
    do_reset();
    cycle();
    chk("rst_idle_busy", bus.busy, 0);
    load_mem();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.rd_en        = ($urandom_range(0, 3) == 0);
      bus.rd_addr      = AW'($urandom_range(0, 20));
      bus.wr_en        = !run && ($urandom_range(0, 2) == 0);
      bus.wr_addr      = AW'($urandom_range(0, 19));
      bus.wr_data      = $urandom;
      bus.stream_start = ($urandom_range(0, 7) == 0);
      bus.stream_base  = AW'($urandom_range(0, 17));
      bus.stream_len   = AW'($urandom_range(0, 20));
      bus.stream_ready = ($urandom_range(0, 2) != 0);
      bus.stream_abort = ($urandom_range(0, 40) == 0);
      cycle();
    end
    idle_inputs();
    bus.stream_ready = 1'b1;
    drain("rand_drain");
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
